exec_issue_ctrl: RTL and testbench

Issue controller that sequences the Execute stage. It accepts one decoded operation at a time over a valid/ready handshake and drives the Execute stage's combinational inputs. It owns the predicate flag register, expands the LDI32 macro-op into four byte-insert micro-ops using `use_imm`/`shift_dist`, and returns results or branch redirects to the pipeline front end.

---
 rtl/exec_issue_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_exec_issue_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_issue_ctrl.sv
// Issue controller for the Execute stage: accepts one decoded op at a time,
// drives Execute's inputs, owns the predicate flag and expands LDI32 into byte inserts.
module exec_issue_ctrl #(
    parameter int DATAW = 32,
    parameter int PCW   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       in_op_i,
    input  logic [DATAW-1:0] in_a_i,
    input  logic [DATAW-1:0] in_b_i,
    input  logic [DATAW-1:0] in_const_i,
    input  logic [PCW-1:0]   in_pc_i,
    input  logic [10:0]      in_imm_i,
    output logic             ex_alu_op_o,
    output logic             ex_branch_in_o,
    output logic             ex_use_imm_o,
    output logic             ex_p_flag_in_o,
    output logic [1:0]       ex_shift_dist_o,
    output logic [DATAW-1:0] ex_a_o,
    output logic [DATAW-1:0] ex_b_o,
    output logic [10:0]      ex_imm_o,
    output logic [PCW-1:0]   ex_pc_o,
    input  logic [DATAW-1:0] ex_out_i,
    input  logic             ex_p_flag_out_i,
    input  logic             ex_branch_out_i,
    input  logic [PCW-1:0]   ex_pc_out_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [DATAW-1:0] res_data_o,
    output logic             redirect_valid_o,
    output logic [PCW-1:0]   redirect_pc_o,
    output logic             busy_o
);

    // One LDI32 step inserts a quarter of the datapath; DATAW/4 must fit the 11-bit imm.
    localparam int Q = DATAW / 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        LDI  = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [DATAW-1:0] a_q;
    logic [DATAW-1:0] b_q;
    logic [DATAW-1:0] const_q;
    logic [PCW-1:0]   pc_q;
    logic [10:0]      imm_q;
    logic             p_flag_q;
    logic [DATAW-1:0] acc_q;
    logic [1:0]       cnt_q;
    logic [DATAW-1:0] res_data_q;
    logic             res_valid_q;
    logic             redirect_valid_q;
    logic [PCW-1:0]   redirect_pc_q;

    logic             accept;
    logic [Q-1:0]     const_slice;

    assign in_ready_o       = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign accept           = in_valid_i && in_ready_o;
    assign res_valid_o      = res_valid_q;
    assign res_data_o       = res_data_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign const_slice      = Q'(const_q >> (32'(cnt_q) * Q));

    // Execute inputs are decoded purely from registered state, so they are glitch-free per cycle.
    always_comb begin
        ex_alu_op_o     = 1'b0;
        ex_branch_in_o  = 1'b0;
        ex_use_imm_o    = 1'b0;
        ex_p_flag_in_o  = 1'b0;
        ex_shift_dist_o = 2'd0;
        ex_a_o          = '0;
        ex_b_o          = '0;
        ex_imm_o        = '0;
        ex_pc_o         = '0;
        case (state_q)
            EXEC: begin
                if (op_q == OP_BR) begin
                    ex_branch_in_o = 1'b1;
                    ex_p_flag_in_o = p_flag_q;
                    ex_pc_o        = pc_q;
                    ex_imm_o       = imm_q;
                end else begin
                    ex_alu_op_o = (op_q == OP_INC);
                    ex_a_o      = a_q;
                    ex_b_o      = b_q;
                end
            end
            LDI: begin
                ex_use_imm_o    = 1'b1;
                ex_shift_dist_o = cnt_q;
                ex_a_o          = acc_q;
                ex_imm_o        = 11'(const_slice);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            op_q             <= OP_ADD;
            a_q              <= '0;
            b_q              <= '0;
            const_q          <= '0;
            pc_q             <= '0;
            imm_q            <= '0;
            p_flag_q         <= 1'b0;
            acc_q            <= '0;
            cnt_q            <= 2'd0;
            res_data_q       <= '0;
            res_valid_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= in_op_i;
                        a_q     <= in_a_i;
                        b_q     <= in_b_i;
                        const_q <= in_const_i;
                        pc_q    <= in_pc_i;
                        imm_q   <= in_imm_i;
                        if (in_op_i == OP_LDI) begin
                            acc_q   <= '0;
                            cnt_q   <= 2'd0;
                            state_q <= LDI;
                        end else begin
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // Branches only consume the flag; ALU ops refresh it and produce a result.
                    if (op_q == OP_BR) begin
                        if (ex_branch_out_i) begin
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= ex_pc_out_i;
                        end
                        state_q <= IDLE;
                    end else begin
                        res_data_q  <= ex_out_i;
                        p_flag_q    <= ex_p_flag_out_i;
                        res_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                LDI: begin
                    acc_q <= ex_out_i;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        res_data_q  <= ex_out_i;
                        res_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Self-checking bench for exec_issue_ctrl: a behavioural Execute stage stands in for the
// real one, and a scoreboard queue holds expected results and redirects.
module tb_exec_issue_ctrl;

    localparam int DATAW = 32;
    localparam int PCW   = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [DATAW-1:0] in_a;
    logic [DATAW-1:0] in_b;
    logic [DATAW-1:0] in_const;
    logic [PCW-1:0]   in_pc;
    logic [10:0]      in_imm;
    logic             ex_alu_op;
    logic             ex_branch_in;
    logic             ex_use_imm;
    logic             ex_p_flag_in;
    logic [1:0]       ex_shift_dist;
    logic [DATAW-1:0] ex_a;
    logic [DATAW-1:0] ex_b;
    logic [10:0]      ex_imm;
    logic [PCW-1:0]   ex_pc;
    logic [DATAW-1:0] ex_out;
    logic             ex_p_flag_out;
    logic             ex_branch_out;
    logic [PCW-1:0]   ex_pc_out;
    logic             res_valid;
    logic             res_ready;
    logic [DATAW-1:0] res_data;
    logic             redirect_valid;
    logic [PCW-1:0]   redirect_pc;
    logic             busy;

    typedef struct {
        bit          isRedirect;
        logic [31:0] value;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    exec_issue_ctrl #(.DATAW(DATAW), .PCW(PCW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_op_i          (in_op),
        .in_a_i           (in_a),
        .in_b_i           (in_b),
        .in_const_i       (in_const),
        .in_pc_i          (in_pc),
        .in_imm_i         (in_imm),
        .ex_alu_op_o      (ex_alu_op),
        .ex_branch_in_o   (ex_branch_in),
        .ex_use_imm_o     (ex_use_imm),
        .ex_p_flag_in_o   (ex_p_flag_in),
        .ex_shift_dist_o  (ex_shift_dist),
        .ex_a_o           (ex_a),
        .ex_b_o           (ex_b),
        .ex_imm_o         (ex_imm),
        .ex_pc_o          (ex_pc),
        .ex_out_i         (ex_out),
        .ex_p_flag_out_i  (ex_p_flag_out),
        .ex_branch_out_i  (ex_branch_out),
        .ex_pc_out_i      (ex_pc_out),
        .res_valid_o      (res_valid),
        .res_ready_i      (res_ready),
        .res_data_o       (res_data),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in Execute stage: add / increment / byte insert / branch target.
    logic [DATAW-1:0] exSum;
    always_comb begin
        exSum = ex_a + ex_b;
        if (ex_use_imm)
            ex_out = ex_a | (DATAW'(ex_imm) << (32'(ex_shift_dist) * 8));
        else if (ex_alu_op)
            ex_out = ex_a + 32'd1;
        else
            ex_out = exSum;
        ex_p_flag_out = ex_alu_op ? (ex_a > ex_b) : (exSum != 32'd0);
        ex_branch_out = ex_branch_in & ex_p_flag_in;
        ex_pc_out     = ex_pc + PCW'(ex_imm);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents a result or redirect.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("res_redirect_exclusive", 64'(res_valid & redirect_valid), 64'd0);
            if (res_valid && res_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", res_data);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("result_kind", 64'(e.isRedirect), 64'd0);
                    checkOutput("res_data", 64'(res_data), 64'(e.value));
                end
            end
            if (redirect_valid) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_redirect: got 0x%0h, expected no redirect", redirect_pc);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("redirect_kind", 64'(e.isRedirect), 64'd1);
                    checkOutput("redirect_pc", 64'(redirect_pc), 64'(e.value));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input bit isRedirect, input logic [31:0] value);
        exp_t e;
        e.isRedirect = isRedirect;
        e.value      = value;
        expQ.push_back(e);
    endtask

    // Called just after a rising edge; returns one step into the cycle following acceptance.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] pc, input logic [10:0] imm);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            nextCycle();
            guard++;
        end
        if (guard >= 50) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_const = c;
        in_pc    = pc;
        in_imm   = imm;
        nextCycle();
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] exAny();
        return 64'(|{ex_alu_op, ex_branch_in, ex_use_imm, ex_p_flag_in, ex_shift_dist,
                     ex_a, ex_b, ex_imm, ex_pc});
    endfunction

    task automatic runAlu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expRes);
        pushExp(1'b0, expRes);
        applyStimulus(op, a, b, 32'd0, 32'd0, 11'd0);
        @(negedge clk);
        checkOutput("alu_ex_alu_op", 64'(ex_alu_op), 64'(op == 2'b01));
        checkOutput("alu_ex_a", 64'(ex_a), 64'(a));
        checkOutput("alu_ex_b", 64'(ex_b), 64'(b));
        checkOutput("alu_ex_use_imm", 64'(ex_use_imm), 64'd0);
        checkOutput("alu_res_valid_early", 64'(res_valid), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("alu_res_valid_n2", 64'(res_valid), 64'd1);
        checkOutput("alu_in_ready_n2", 64'(in_ready), 64'd0);
        nextCycle();
    endtask

    task automatic runBr(input logic [31:0] pc, input logic [10:0] imm, input bit expFlag,
                         input logic [31:0] expTarget);
        if (expFlag) pushExp(1'b1, expTarget);
        applyStimulus(2'b10, 32'd0, 32'd0, 32'd0, pc, imm);
        @(negedge clk);
        checkOutput("br_ex_branch_in", 64'(ex_branch_in), 64'd1);
        checkOutput("br_ex_p_flag_in", 64'(ex_p_flag_in), 64'(expFlag));
        checkOutput("br_ex_pc", 64'(ex_pc), 64'(pc));
        checkOutput("br_ex_imm", 64'(ex_imm), 64'(imm));
        nextCycle();
        @(negedge clk);
        checkOutput("br_redirect_n2", 64'(redirect_valid), 64'(expFlag));
        checkOutput("br_in_ready_n2", 64'(in_ready), 64'd1);
        checkOutput("br_no_res_valid", 64'(res_valid), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("br_redirect_one_cycle", 64'(redirect_valid), 64'd0);
        nextCycle();
    endtask

    logic [10:0] ldiImm [4];
    logic [31:0] ldiAcc [4];

    initial begin
        ldiImm = '{11'h0EF, 11'h0BE, 11'h0AD, 11'h0DE};
        ldiAcc = '{32'h0, 32'h0000_00EF, 32'h0000_BEEF, 32'h00AD_BEEF};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_const  = '0;
        in_pc     = '0;
        in_imm    = '0;
        res_ready = 1'b1;
        repeat (3) nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset_redirect", 64'(redirect_valid), 64'd0);
        checkOutput("reset_res_data", 64'(res_data), 64'd0);
        checkOutput("reset_ex_all_zero", exAny(), 64'd0);
        nextCycle();

        $display("[TB] ALU and branch sequences");
        runAlu(2'b00, 32'd5, 32'd7, 32'd12);
        runBr(32'h100, 11'h20, 1'b1, 32'h120);
        runAlu(2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        runBr(32'h100, 11'h20, 1'b0, 32'h0);
        runAlu(2'b01, 32'd9, 32'd3, 32'd10);
        runBr(32'h100, 11'h20, 1'b1, 32'h120);
        runAlu(2'b01, 32'd3, 32'd9, 32'd4);

        $display("[TB] LDI32 expansion");
        pushExp(1'b0, 32'hDEAD_BEEF);
        applyStimulus(2'b11, 32'd0, 32'd0, 32'hDEAD_BEEF, 32'd0, 11'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("ldi_shift_dist_%0d", i), 64'(ex_shift_dist), 64'(i));
            checkOutput($sformatf("ldi_imm_%0d", i), 64'(ex_imm), 64'(ldiImm[i]));
            checkOutput($sformatf("ldi_acc_%0d", i), 64'(ex_a), 64'(ldiAcc[i]));
            checkOutput($sformatf("ldi_use_imm_%0d", i), 64'(ex_use_imm), 64'd1);
            checkOutput($sformatf("ldi_res_valid_%0d", i), 64'(res_valid), 64'd0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("ldi_res_valid_n5", 64'(res_valid), 64'd1);
        nextCycle();
        runBr(32'h100, 11'h20, 1'b0, 32'h0);

        $display("[TB] result back-pressure");
        res_ready = 1'b0;
        pushExp(1'b0, 32'd5);
        applyStimulus(2'b00, 32'd2, 32'd3, 32'd0, 32'd0, 11'd0);
        nextCycle();
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_a     = 32'd100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_res_valid_%0d", k), 64'(res_valid), 64'd1);
            checkOutput($sformatf("stall_res_data_%0d", k), 64'(res_data), 64'd5);
            checkOutput($sformatf("stall_in_ready_%0d", k), 64'(in_ready), 64'd0);
            checkOutput($sformatf("stall_busy_%0d", k), 64'(busy), 64'd1);
            nextCycle();
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready_m", 64'(in_ready), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("release_in_ready_m1", 64'(in_ready), 64'd1);
        checkOutput("release_res_valid_m1", 64'(res_valid), 64'd0);
        nextCycle();

        $display("[TB] reset during LDI32");
        applyStimulus(2'b11, 32'd0, 32'd0, 32'h1234_5678, 32'd0, 11'd0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("abort_at_cnt2", 64'(ex_shift_dist), 64'd2);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_res_valid", 64'(res_valid), 64'd0);
        checkOutput("abort_ex_all_zero", exAny(), 64'd0);
        nextCycle();
        runBr(32'h100, 11'h20, 1'b0, 32'h0);
        repeat (10) nextCycle();

        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
